// File: rtl/mem_wb_stage_if.sv
// MEM/WB pipeline-stage interface: MEM-stage inputs, pipeline control, and
// the registered WB-stage outputs. clk and rst stay plain module ports.
interface mem_wb_stage_if;
    // Pipeline control
    logic        stall;
    logic        flush;

    // MEM-stage instruction fields
    logic        valid_i;
    logic [31:0] alu_result_i;
    logic [31:0] load_data_i;
    logic [31:0] pc_i;
    logic [4:0]  rd_addr_i;
    logic        reg_wr_i;
    logic [1:0]  wb_sel_i;
    logic [2:0]  funct3_i;

    // WB-stage registered outputs
    logic [31:0] alu_result_o;
    logic [31:0] load_data_o;
    logic [31:0] pc_plus4_o;
    logic [1:0]  wb_sel_o;
    logic [4:0]  rd_addr_o;
    logic        reg_wr_o;
    logic        valid_o;
    logic [31:0] instret_o;

    // Upstream side: drives the MEM-stage fields and control, sees WB outputs.
    modport master (
        output stall, flush, valid_i, alu_result_i, load_data_i, pc_i,
               rd_addr_i, reg_wr_i, wb_sel_i, funct3_i,
        input  alu_result_o, load_data_o, pc_plus4_o, wb_sel_o, rd_addr_o,
               reg_wr_o, valid_o, instret_o
    );

    // Stage side: the pipeline register itself.
    modport slave (
        input  stall, flush, valid_i, alu_result_i, load_data_i, pc_i,
               rd_addr_i, reg_wr_i, wb_sel_i, funct3_i,
        output alu_result_o, load_data_o, pc_plus4_o, wb_sel_o, rd_addr_o,
               reg_wr_o, valid_o, instret_o
    );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register. Aligns and extends load data ahead of the
// register, qualifies the register-file write, and counts retired
// instructions. Priority per edge: rst, flush, stall, capture.
module mem_wb_stage (
    input  logic           clk,
    input  logic           rst,
    mem_wb_stage_if.slave  bus
);
    // Load types carried in funct3.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]  w_off;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_ext;
    logic        w_reg_wr;

    logic [31:0] r_alu_result;
    logic [31:0] r_load_data;
    logic [31:0] r_pc_plus4;
    logic [1:0]  r_wb_sel;
    logic [4:0]  r_rd_addr;
    logic        r_reg_wr;
    logic        r_valid;
    logic [31:0] r_instret;

    assign w_off = bus.alu_result_i[1:0];

    // Pick the addressed byte/halfword and extend it by load type; misaligned
    // halfwords use only off[1], words ignore the offset entirely.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_byte     = bus.load_data_i[7:0];
        w_half     = bus.load_data_i[15:0];
        w_load_ext = bus.load_data_i;

        case (w_off)
            2'd0:    w_byte = bus.load_data_i[7:0];
            2'd1:    w_byte = bus.load_data_i[15:8];
            2'd2:    w_byte = bus.load_data_i[23:16];
            default: w_byte = bus.load_data_i[31:24];
        endcase

        if (w_off[1]) begin
            w_half = bus.load_data_i[31:16];
        end

        case (bus.funct3_i)
            F3_LB:   w_load_ext = {{24{w_byte[7]}}, w_byte};
            F3_LBU:  w_load_ext = {24'h0, w_byte};
            F3_LH:   w_load_ext = {{16{w_half[15]}}, w_half};
            F3_LHU:  w_load_ext = {16'h0, w_half};
            default: w_load_ext = bus.load_data_i;
        endcase
    end

    // Writes to x0 and writes from bubbles never reach the register file.
    assign w_reg_wr = bus.reg_wr_i & bus.valid_i & (bus.rd_addr_i != 5'd0);

    // Pipeline register and retire counter.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_alu_result <= 32'h0;
            r_load_data  <= 32'h0;
            r_pc_plus4   <= 32'h0;
            r_wb_sel     <= 2'b00;
            r_rd_addr    <= 5'd0;
            r_reg_wr     <= 1'b0;
            r_valid      <= 1'b0;
            r_instret    <= 32'h0;
        end else if (bus.flush) begin
            // Bubble: kill the slot but leave the data and counter untouched.
            r_valid  <= 1'b0;
            r_reg_wr <= 1'b0;
        end else if (!bus.stall) begin
            r_alu_result <= bus.alu_result_i;
            r_load_data  <= w_load_ext;
            r_pc_plus4   <= bus.pc_i + 32'd4;
            r_wb_sel     <= bus.wb_sel_i;
            r_rd_addr    <= bus.rd_addr_i;
            r_reg_wr     <= w_reg_wr;
            r_valid      <= bus.valid_i;
            if (bus.valid_i) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign bus.alu_result_o = r_alu_result;
    assign bus.load_data_o  = r_load_data;
    assign bus.pc_plus4_o   = r_pc_plus4;
    assign bus.wb_sel_o     = r_wb_sel;
    assign bus.rd_addr_o    = r_rd_addr;
    assign bus.reg_wr_o     = r_reg_wr;
    assign bus.valid_o      = r_valid;
    assign bus.instret_o    = r_instret;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: a behavioural reference model checked
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_mem_wb_stage;
    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;
    logic cmp_en   = 1'b0;
    logic preload  = 1'b0;

    mem_wb_stage_if bus ();

    mem_wb_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference load extraction: shift the word so the addressed unit sits at
    // bit 0, mask it, then extend by load type.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a,
                                             input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
        h = (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    // Model state: what the WB slot must hold after each edge.
    logic [31:0] m_alu, m_load, m_pc4, m_instret;
    logic [1:0]  m_sel;
    logic [4:0]  m_rd;
    logic        m_rw, m_valid;

    always @(posedge clk) begin : model
        logic [31:0] base;
        base = preload ? 32'hFFFF_FFFF : m_instret;
        if (rst) begin
            cmp_en    <= 1'b1;
            m_alu     <= '0; m_load <= '0; m_pc4 <= '0; m_sel <= '0;
            m_rd      <= '0; m_rw   <= 1'b0; m_valid <= 1'b0;
            m_instret <= '0;
        end else if (bus.flush) begin
            m_valid   <= 1'b0;
            m_rw      <= 1'b0;
            m_instret <= base;
        end else if (bus.stall) begin
            m_instret <= base;
        end else begin
            m_alu     <= bus.alu_result_i;
            m_load    <= ref_load(bus.load_data_i, bus.alu_result_i, bus.funct3_i);
            m_pc4     <= bus.pc_i + 32'd4;
            m_sel     <= bus.wb_sel_i;
            m_rd      <= bus.rd_addr_i;
            m_rw      <= bus.valid_i && bus.reg_wr_i && (bus.rd_addr_i != 0);
            m_valid   <= bus.valid_i;
            m_instret <= base + (bus.valid_i ? 32'd1 : 32'd0);
        end
    end

    // Compare every output against the model each cycle, away from posedge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc alu_result_o", bus.alu_result_o, m_alu);
            check("cyc load_data_o",  bus.load_data_o,  m_load);
            check("cyc pc_plus4_o",   bus.pc_plus4_o,   m_pc4);
            check("cyc wb_sel_o",     {30'h0, bus.wb_sel_o}, {30'h0, m_sel});
            check("cyc rd_addr_o",    {27'h0, bus.rd_addr_o}, {27'h0, m_rd});
            check("cyc reg_wr_o",     {31'h0, bus.reg_wr_o}, {31'h0, m_rw});
            check("cyc valid_o",      {31'h0, bus.valid_o},  {31'h0, m_valid});
            check("cyc instret_o",    bus.instret_o, m_instret);
        end
    end

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [2:0] f3);
        bus.valid_i      = v;
        bus.alu_result_i = alu;
        bus.load_data_i  = ld;
        bus.pc_i         = pc;
        bus.rd_addr_i    = rd;
        bus.reg_wr_i     = rw;
        bus.wb_sel_i     = sel;
        bus.funct3_i     = f3;
    endtask

    task automatic drive_random();
        drive(1'($urandom), $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom),
              2'($urandom), 3'($urandom));
        bus.stall = 1'($urandom);
        bus.flush = 1'($urandom);
    endtask

    // Capture one normal instruction; returns after the following negedge.
    task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [31:0] pc, input logic [4:0] rd, input logic rw,
                         input logic [1:0] sel, input logic [2:0] f3);
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(v, alu, ld, pc, rd, rw, sel, f3);
        @(negedge clk);
    endtask

    localparam logic [31:0] LD = 32'h8899_AABB;

    initial begin
        rst = 1'b1;
        drive_random();
        @(negedge clk);
        drive_random();
        @(negedge clk);
        check("reset alu_result_o", bus.alu_result_o, 32'h0);
        check("reset load_data_o",  bus.load_data_o,  32'h0);
        check("reset pc_plus4_o",   bus.pc_plus4_o,   32'h0);
        check("reset wb_sel_o",     {30'h0, bus.wb_sel_o}, 32'h0);
        check("reset valid_reg_wr", {30'h0, bus.valid_o, bus.reg_wr_o}, 32'h0);
        check("reset instret_o",    bus.instret_o, 32'h0);

        // First capture on the first edge with rst low.
        rst = 1'b0;
        issue(1'b1, 32'h1002, LD, 32'h100, 5'd5, 1'b1, 2'b01, 3'd0);
        check("lb 0x1002",        bus.load_data_o, 32'hFFFF_FF99);
        check("first pc_plus4",   bus.pc_plus4_o,  32'h0000_0104);
        check("first instret",    bus.instret_o,   32'd1);
        check("first reg_wr",     {31'h0, bus.reg_wr_o}, 32'd1);
        issue(1'b1, 32'h1002, LD, 32'h104, 5'd5, 1'b1, 2'b01, 3'd4);
        check("lbu 0x1002",       bus.load_data_o, 32'h0000_0099);
        issue(1'b1, 32'h1003, LD, 32'h108, 5'd6, 1'b1, 2'b01, 3'd1);
        check("lh 0x1003",        bus.load_data_o, 32'hFFFF_8899);
        issue(1'b1, 32'h1001, LD, 32'h10C, 5'd6, 1'b1, 2'b01, 3'd5);
        check("lhu 0x1001",       bus.load_data_o, 32'h0000_AABB);
        issue(1'b1, 32'h1003, LD, 32'h110, 5'd6, 1'b1, 2'b01, 3'd2);
        check("lw misaligned",    bus.load_data_o, LD);
        issue(1'b1, 32'h1001, LD, 32'h114, 5'd6, 1'b1, 2'b01, 3'd3);
        check("funct3=3 raw",     bus.load_data_o, LD);
        issue(1'b1, 32'h1000, LD, 32'h118, 5'd6, 1'b1, 2'b01, 3'd0);
        check("lb 0x1000",        bus.load_data_o, 32'hFFFF_FFBB);
        issue(1'b1, 32'h1001, LD, 32'h11C, 5'd6, 1'b1, 2'b01, 3'd4);
        check("lbu 0x1001",       bus.load_data_o, 32'h0000_00AA);
        issue(1'b1, 32'h1003, LD, 32'h120, 5'd6, 1'b1, 2'b01, 3'd0);
        check("lb 0x1003",        bus.load_data_o, 32'hFFFF_FF88);
        check("instret after 9",  bus.instret_o,   32'd9);

        // Write qualification.
        issue(1'b1, 32'h0, 32'h0, 32'h200, 5'd0, 1'b1, 2'b00, 3'd2);
        check("rd0 reg_wr",       {31'h0, bus.reg_wr_o}, 32'd0);
        check("rd0 instret",      bus.instret_o, 32'd10);
        issue(1'b0, 32'h0, 32'h0, 32'h204, 5'd7, 1'b1, 2'b00, 3'd2);
        check("invalid reg_wr",   {31'h0, bus.reg_wr_o}, 32'd0);
        check("invalid valid_o",  {31'h0, bus.valid_o},  32'd0);
        check("invalid instret",  bus.instret_o, 32'd10);

        // PC wrap plus a reference instruction to freeze.
        issue(1'b1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hFFFF_FFFC, 5'd9, 1'b1, 2'b10, 3'd2);
        check("pc wrap",          bus.pc_plus4_o, 32'h0);
        check("wrap instret",     bus.instret_o,  32'd11);

        // Stall 3 cycles with changing inputs.
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;
            drive(1'b1, 32'h5000 + i, 32'hA5A5_0000 + i, 32'h3000 + i, 5'(i + 1), 1'b1,
                  2'(i), 3'(i));
            @(negedge clk);
            check("stall alu_result", bus.alu_result_o, 32'hDEAD_BEEF);
            check("stall instret",    bus.instret_o,    32'd11);
        end

        // Flush together with stall: bubble, data held.
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive(1'b1, 32'h7777_0000, 32'h0, 32'h400, 5'd3, 1'b1, 2'b00, 3'd2);
        @(negedge clk);
        check("flush valid_o",    {31'h0, bus.valid_o},  32'd0);
        check("flush reg_wr_o",   {31'h0, bus.reg_wr_o}, 32'd0);
        check("flush alu held",   bus.alu_result_o, 32'hDEAD_BEEF);
        check("flush load held",  bus.load_data_o,  32'h1234_5678);
        check("flush rd held",    {27'h0, bus.rd_addr_o}, 32'd9);
        // Flush alone with valid_i=1 must not retire.
        bus.stall = 1'b0;
        @(negedge clk);
        check("flush no retire",  bus.instret_o, 32'd11);

        // Reset asserted mid-stall discards the held instruction.
        issue(1'b1, 32'h6000, 32'h0, 32'h500, 5'd4, 1'b1, 2'b00, 3'd2);
        bus.stall = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst in stall valid",   {31'h0, bus.valid_o}, 32'd0);
        check("rst in stall alu",     bus.alu_result_o, 32'h0);
        check("rst in stall instret", bus.instret_o, 32'h0);
        rst = 1'b0;

        // Back-to-back stream with every wb_sel encoding.
        for (int i = 0; i < 5; i++) begin
            logic [1:0] sel;
            sel = (i == 4) ? 2'b00 : 2'(i);
            issue(1'b1, 32'h0A00 + 4 * i, 32'hC0DE_0000 + i, 32'h800 + 4 * i, 5'(10 + i),
                  1'b1, sel, 3'd2);
            check("b2b wb_sel",  {30'h0, bus.wb_sel_o}, {30'h0, sel});
            check("b2b pc_plus4", bus.pc_plus4_o, 32'h804 + 4 * i);
        end
        check("b2b instret", bus.instret_o, 32'd5);

        // Counter wrap: preload 0xFFFFFFFF while stalled, then retire one.
        bus.stall = 1'b1;
        #1;
        force dut.r_instret = 32'hFFFF_FFFF;
        preload = 1'b1;
        #1;
        release dut.r_instret;
        @(negedge clk);
        preload = 1'b0;
        check("preload instret", bus.instret_o, 32'hFFFF_FFFF);
        issue(1'b1, 32'h0, 32'h0, 32'h900, 5'd1, 1'b1, 2'b00, 3'd2);
        check("instret wrap", bus.instret_o, 32'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 stall  input  1  hold all registered state.
REQ-005 flush  input  1  insert a bubble.
REQ-006 valid_i  input  1  the incoming MEM-stage instruction is real.
REQ-007 alu_result_i  input  32  ALU result / effective address.
REQ-008 load_data_i  input  32  raw aligned word from data memory.
REQ-009 pc_i  input  32  PC of the MEM-stage instruction.
REQ-010 rd_addr_i  input  5  destination register.
REQ-011 reg_wr_i  input  1  instruction writes rd.
REQ-012 wb_sel_i  input  2  writeback source: 00 ALU, 01 load, 10 PC+4.
REQ-013 funct3_i  input  3  load type.
REQ-014 alu_result_o  output  32  registered ALU result (writeback mux input 0).
REQ-015 load_data_o  output  32  registered, aligned and extended load data (writeback mux input 1).
REQ-016 pc_plus4_o  output  32  registered PC+4 (writeback mux input 2).
REQ-017 wb_sel_o  output  2  registered select for the writeback mux.
REQ-018 rd_addr_o  output  5  registered destination register.
REQ-019 reg_wr_o  output  1  qualified register-file write enable.
REQ-020 valid_o  output  1  the WB-stage slot holds a real instruction.
REQ-021 instret_o  output  32  count of retired instructions.

Function
REQ-022 Latency SHALL be exactly 1 cycle from inputs to outputs when not stalled, flushed or reset.
REQ-023 Update priority per rising edge SHALL be: rst, then flush, then stall, then normal capture.
REQ-024 Flush SHALL:
- set valid_o=0 and reg_wr_o=0;
- hold all data outputs and instret_o;
- apply even when stall=1.
REQ-025 Stall (no flush) SHALL hold every output, including instret_o.
REQ-026 Normal capture SHALL:
- register all *_i fields;
- set valid_o=valid_i;
- set reg_wr_o = reg_wr_i AND valid_i AND (rd_addr_i != 0).
REQ-027 pc_plus4_o SHALL be pc_i+4 modulo 2^32; 0xFFFFFFFC SHALL yield 0x00000000.
REQ-028 Load extraction SHALL use off = alu_result_i[1:0]:
- 000 (lb): byte at bits [8*off+7 : 8*off], sign-extended;
- 100 (lbu): the same byte, zero-extended;
- 001 (lh): halfword selected by off[1], sign-extended;
- 101 (lhu): the same halfword, zero-extended;
- 010 (lw): the raw word.
REQ-029 Any other funct3 value SHALL pass the raw word through unchanged.
REQ-030 Misaligned access SHALL NOT trap; selection SHALL use only the address bits named in REQ-028, so lh/lhu ignore off[0] and lw ignores off entirely.
REQ-031 Load extraction SHALL be computed combinationally before the register, so load_data_o is registered.
REQ-032 wb_sel_i=11 SHALL be captured unmodified (downstream default selects the ALU).
REQ-033 instret_o SHALL increment by 1 on each normal capture with valid_i=1 and wrap 0xFFFFFFFF to 0.
REQ-034 Simultaneous flush and valid_i=1 SHALL NOT increment instret_o.

Reset
REQ-035 While rst=1 at a rising edge, every output SHALL become 0 (wb_sel_o=00, valid_o=0, reg_wr_o=0, instret_o=0), regardless of stall or flush.
REQ-036 Reset asserted mid-stall SHALL discard the held instruction.
REQ-037 The first capture SHALL occur on the first rising edge with rst=0.

Verification
REQ-038 Reset: assert rst for 2 cycles with random inputs -> all outputs 0.
REQ-039 Load extraction, load_data_i=0x8899AABB:
- lb, addr=0x1002 -> load_data_o=0xFFFFFF99 one cycle later;
- lbu, same address -> 0x00000099;
- lh, addr=0x1003 -> 0xFFFF8899.
REQ-040 Register write qualification:
- rd_addr_i=0, reg_wr_i=1, valid_i=1 -> reg_wr_o=0, instret_o increments;
- valid_i=0 -> reg_wr_o=0, instret_o unchanged.
REQ-041 Stall and flush:
- stall for 3 cycles while inputs change -> outputs frozen;
- flush together with stall -> valid_o=0, reg_wr_o=0, data outputs unchanged.
REQ-042 Wrap-around:
- pc_i=0xFFFFFFFC -> pc_plus4_o=0x00000000;
- instret_o preloaded to 0xFFFFFFFF via 2^32-1 valid captures (or forced) -> next valid capture gives 0.
REQ-043 Back-to-back stream: 5 valid instructions with wb_sel 00/01/10/11/00 on consecutive cycles -> outputs match each one cycle later, instret_o=5.
